sop4_sweep_ctrl: RTL and testbench

- Self-test sequencer for the 4-input sum-of-products lamp network, F = A'BC' + AB'D' + AB'C' + C'D'.
- Replaces the four manual switches: the block drives every input combination onto A/B/C/D in turn, waits for the gate network to settle, and samples the lamp net.
- It assembles the 16-entry truth table, compares it against a golden mask, and reports pass/fail and mismatch details.
- It sits between the lab's stimulus panel and the combinational network under test.

---
 rtl/sop4_sweep_ctrl_if.sv | 35 +++
 rtl/sop4_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_sop4_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sop4_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sop4_sweep_ctrl_if
// Brief    : Stimulus/observation bundle between the sweep sequencer and the
//            4-input SOP lamp network plus its reporting outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface sop4_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic        f_in;
    logic        vec_a;
    logic        vec_b;
    logic        vec_c;
    logic        vec_d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  mismatch_idx;

    modport slave (
        input  start, abort, f_in,
        output vec_a, vec_b, vec_c, vec_d, busy, done,
               table_out, pass, mismatch_cnt, mismatch_idx
    );

    modport master (
        output start, abort, f_in,
        input  vec_a, vec_b, vec_c, vec_d, busy, done,
               table_out, pass, mismatch_cnt, mismatch_idx
    );
endinterface
`default_nettype wire

// File: rtl/sop4_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sop4_sweep_ctrl
// Brief    : Sweeps all 16 A/B/C/D vectors through the lamp network, samples
//            the lamp after settling and grades the table against a golden mask.
// Revision : 1.0 - initial release
// ============================================================================
module sop4_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h1731
) (
    input  wire             clk,
    input  wire             rst,
    sop4_sweep_ctrl_if.slave bus
);

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_last_idx    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic        r_pass;
    logic [4:0]  r_mis_cnt;
    logic [3:0]  r_mis_idx;

    logic        w_mis;
    logic [15:0] w_table_next;

    assign w_mis        = (bus.f_in != EXPECTED[r_idx]);
    assign w_table_next = (r_table & ~(16'h0001 << r_idx)) | (16'(bus.f_in) << r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= 16'h0000;
            r_pass    <= 1'b0;
            r_mis_cnt <= 5'd0;
            r_mis_idx <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort outranks start here, so nothing is cleared when both are high
                    if (bus.start && !bus.abort) begin
                        r_idx     <= 4'd0;
                        r_cnt     <= c_settle_load;
                        r_busy    <= 1'b1;
                        r_table   <= 16'h0000;
                        r_pass    <= 1'b0;
                        r_mis_cnt <= 5'd0;
                        r_mis_idx <= 4'd0;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    // an abort on the sample edge drops this vector's result
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_table <= w_table_next;
                        if (w_mis) begin
                            r_mis_cnt <= r_mis_cnt + 5'd1;
                            if (r_mis_cnt == 5'd0) begin
                                r_mis_idx <= r_idx;
                            end
                        end
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_table_next == EXPECTED);
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_cnt   <= c_settle_load;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.vec_a        = r_idx[3];
    assign bus.vec_b        = r_idx[2];
    assign bus.vec_c        = r_idx[1];
    assign bus.vec_d        = r_idx[0];
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.table_out    = r_table;
    assign bus.pass         = r_pass;
    assign bus.mismatch_cnt = r_mis_cnt;
    assign bus.mismatch_idx = r_mis_idx;

endmodule
`default_nettype wire

// File: tb/tb_sop4_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sop4_sweep_ctrl
// Brief    : Directed bench for sop4_sweep_ctrl with a lamp-network model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sop4_sweep_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   fault0;
    int   cur_sel;

    sop4_sweep_ctrl_if if0 ();
    sop4_sweep_ctrl_if if1 ();

    sop4_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(16'h1731)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sop4_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(16'h1731)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: intact network, 1: C'D' term missing, 2: lamp stuck at 1
    function automatic logic f_model(input logic [3:0] v, input int mode);
        logic a, b, c, d, f;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        f = (~a & b & ~c) | (a & ~b & ~d) | (a & ~b & ~c);
        if (mode == 2)      return 1'b1;
        else if (mode == 1) return f;
        else                return f | (~c & ~d);
    endfunction

    assign if0.f_in = f_model({if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d}, fault0);
    assign if1.f_in = f_model({if1.vec_a, if1.vec_b, if1.vec_c, if1.vec_d}, 0);

    logic       m_busy;
    logic       m_done;
    logic [3:0] m_vec;
    always_comb begin
        m_busy = if0.busy;
        m_done = if0.done;
        m_vec  = {if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d};
        if (cur_sel == 1) begin
            m_busy = if1.busy;
            m_done = if1.done;
            m_vec  = {if1.vec_a, if1.vec_b, if1.vec_c, if1.vec_d};
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Pulses start, then follows the sweep cycle by cycle until done (bounded).
    task automatic run_sweep(input int sel, input int per, input string tag,
                             output int nbusy, output int ndone);
        int vec_err;
        bit seen_done;
        vec_err   = 0;
        seen_done = 0;
        nbusy     = 0;
        ndone     = 0;
        cur_sel   = sel;
        if (sel == 0) if0.start = 1'b1;
        else          if1.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
            if (m_busy) begin
                nbusy++;
                if (m_vec !== 4'((nbusy - 1) / per)) vec_err++;
            end
            if (m_done) begin
                ndone     = cyc;
                seen_done = 1;
                if (m_busy) vec_err++;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " vec_seq"}, 32'(vec_err), 32'd0);
        chk({tag, " done_seen"}, 32'(seen_done), 32'd1);
    endtask

    task automatic wait_vec0(input logic [3:0] v, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if ({if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d} == v && if0.busy) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    function automatic logic [31:0] all_out0();
        return {if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d, if0.busy, if0.done,
                if0.table_out, if0.pass, if0.mismatch_cnt, if0.mismatch_idx};
    endfunction

    initial begin
        int  nb, nd, restarts, dones;
        bit  ok;
        logic [3:0] prev;
        checks    = 0;
        errors    = 0;
        fault0    = 0;
        cur_sel   = 0;
        rst       = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("reset outputs", all_out0(), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle after reset busy", 32'(if0.busy), 32'd0);

        // golden network
        run_sweep(0, 3, "golden", nb, nd);
        chk("golden busy_cycles", 32'(nb), 32'd48);
        chk("golden done_cycle", 32'(nd), 32'd49);
        chk("golden table", 32'(if0.table_out), 32'h1731);
        chk("golden pass", 32'(if0.pass), 32'd1);
        chk("golden mis_cnt", 32'(if0.mismatch_cnt), 32'd0);
        @(posedge clk); #1;
        chk("golden done_one_cycle", 32'(if0.done), 32'd0);
        chk("golden pass_held", 32'(if0.pass), 32'd1);

        // missing C'D' term
        fault0 = 1;
        run_sweep(0, 3, "noCD", nb, nd);
        chk("noCD table", 32'(if0.table_out), 32'h0730);
        chk("noCD pass", 32'(if0.pass), 32'd0);
        chk("noCD mis_cnt", 32'(if0.mismatch_cnt), 32'd2);
        chk("noCD mis_idx", 32'(if0.mismatch_idx), 32'd0);
        @(posedge clk); #1;

        // stuck-at-1 lamp
        fault0 = 2;
        run_sweep(0, 3, "stuck1", nb, nd);
        chk("stuck1 table", 32'(if0.table_out), 32'hFFFF);
        chk("stuck1 mis_cnt", 32'(if0.mismatch_cnt), 32'd9);
        chk("stuck1 mis_idx", 32'(if0.mismatch_idx), 32'd1);
        chk("stuck1 pass", 32'(if0.pass), 32'd0);
        @(posedge clk); #1;

        // abort in SETTLE at idx 5
        fault0 = 0;
        cur_sel = 0;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        wait_vec0(4'd5, ok);
        chk("abort reach_idx5", 32'(ok), 32'd1);
        if0.abort = 1'b1;
        @(posedge clk); #1;
        if0.abort = 1'b0;
        chk("abort busy", 32'(if0.busy), 32'd0);
        chk("abort vec", 32'({if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d}), 32'd0);
        chk("abort pass", 32'(if0.pass), 32'd0);
        chk("abort table", 32'(if0.table_out), 32'h0011);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (if0.done || if0.busy) dones++;
            @(posedge clk); #1;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        if0.start = 1'b1; if0.abort = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0; if0.abort = 1'b0;
        chk("start+abort busy", 32'(if0.busy), 32'd0);
        chk("start+abort table", 32'(if0.table_out), 32'h0011);
        @(posedge clk); #1;
        chk("start+abort still_idle", 32'(if0.busy), 32'd0);

        // start held through the sweep, then async reset at idx 9
        if0.start = 1'b1;
        @(posedge clk); #1;
        prev = 4'd0;
        restarts = 0;
        dones = 0;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if ({if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d} < prev) restarts++;
            if (if0.done || !if0.busy) dones++;
            prev = {if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d};
            if (prev == 4'd9) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("hold reach_idx9", 32'(ok), 32'd1);
        chk("hold no_restart", 32'(restarts), 32'd0);
        chk("hold stays_busy", 32'(dones), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midsweep reset outputs", all_out0(), 32'd0);
        if0.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post reset idle", 32'(if0.busy), 32'd0);

        run_sweep(0, 3, "after_rst", nb, nd);
        chk("after_rst busy_cycles", 32'(nb), 32'd48);
        chk("after_rst done_cycle", 32'(nd), 32'd49);
        chk("after_rst table", 32'(if0.table_out), 32'h1731);
        chk("after_rst pass", 32'(if0.pass), 32'd1);
        @(posedge clk); #1;

        // SETTLE_CYCLES = 1 instance
        run_sweep(1, 2, "settle1", nb, nd);
        chk("settle1 busy_cycles", 32'(nb), 32'd32);
        chk("settle1 done_cycle", 32'(nd), 32'd33);
        chk("settle1 table", 32'(if1.table_out), 32'h1731);
        chk("settle1 pass", 32'(if1.pass), 32'd1);
        chk("settle1 mis_cnt", 32'(if1.mismatch_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
